jk_mod_counter: RTL and testbench
=================================

# jk_mod_counter

Synchronous up/down modulo-N counter whose state bits are held in edge-triggered JK storage cells, with the J/K excitation logic generated per bit from the current and desired next state. It is the stage that consumes the JK flip-flop primitive: it drives J/K inputs every cycle and turns the resulting Q bits into a usable count, terminal-count and wrap status for downstream sequencing blocks.

## Interface
- WIDTH, 4: counter bit width; 2..16.
- MOD, 10: count modulus; legal counts 0..MOD-1; 2 ≤ MOD ≤ 2^WIDTH.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- en  in  1  count enable; one step per cycle when high.
- up  in  1  direction; 1 = increment, 0 = decrement.
- load  in  1  synchronous load of din; overrides en.
- din  in  WIDTH  load value.
- q  out  WIDTH  current count (the JK cell Q bits).
- tc  out  1  terminal count, combinational: en & ~load & ((up & q==MOD-1) | (~up & q==0)).
- wrap  out  1  registered one-cycle pulse: the previous edge wrapped the count.
- load_err  out  1  registered one-cycle pulse: the previous edge loaded an out-of-range din.
- j_dbg  out  WIDTH  J vector applied this cycle (combinational).
- k_dbg  out  WIDTH  K vector applied this cycle (combinational).

## Operation
- Priority on each edge: rst > load > en > hold.
- rst: q=0, wrap=0, load_err=0. All JK cells are forced to reset through J=0, K=1 for every bit, not through a separate storage path.
- load: next = din if din < MOD, else MOD-1 with load_err=1 on the following cycle; wrap=0.
- en & up: next = (q==MOD-1) ? 0 : q+1. The wrap flag is set when q==MOD-1.
- en & ~up: next = (q==0) ? MOD-1 : q-1. The wrap flag is set when q==0.
- Hold (en=0, load=0): next = q, and J=K=0 for all bits.
- Excitation for each bit i: J[i] = next[i] & ~q[i], and K[i] = ~next[i] & q[i]. Hold, set and reset commands only; the toggle command (J=K=1) is never issued.
- Arithmetic is done in WIDTH+1 bits so that q+1 never overflows before the modulus compare. When MOD = 2^WIDTH, this gives natural binary wrap.
- Out-of-range q (≥ MOD) cannot occur functionally. If it is forced in simulation, the next enabled up-step goes to 0, down-step goes to q-1, and wrap does not assert.
- load together with en: load wins and no count step is taken that cycle.
- Direction change mid-count is legal and takes effect on the same cycle that up changes.

## Timing
- Count latency: 1 cycle from en sampled high to q updated.
- Load latency: q equals din (or the clamped value) after the loading edge.
- tc is combinational in the same cycle as the terminal state. wrap is high the cycle after tc was high and en stepped.
- Back-to-back wraps (MOD=2, en held): wrap pulses every cycle that follows a terminal step.
- rst asserted mid-count: q=0 on that edge; wrap and load_err are cleared on that same edge even if a wrap or load coincided.
- rst released: the first count step occurs on the next edge where en=1.

## Structure
- Shared package jk_pkg:
  - jk_cmd_t enum: HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11.
  - Function jk_excite(cur, nxt) returning jk_cmd_t.
- Sub-module jk_cell: one edge-triggered JK bit.
  - Ports: clk, j, k, q.
  - Truth: 00 hold, 01 reset, 10 set, 11 toggle.
  - No reset port; reset is achieved through J/K.
  - Instantiate it WIDTH times with a generate loop.
- Top level holds next-state, clamp, excitation, tc, and the wrap/load_err registers.

## Test plan
- Reset then count (WIDTH=4, MOD=10, up=1, en=1 for 12 cycles): q goes 0,1,…,9,0,1. tc is high while q=9. wrap pulses once on the cycle q=0 after 9.
- Down wrap (load din=0, then up=0, en=1): q goes 0→9→8. tc is high at q=0. wrap pulses on the cycle q=9. The J/K pattern at 0→9 is j_dbg=4'b1001, k_dbg=0.
- Load clamp (load=1, din=12): q=9 on the next cycle and load_err pulses one cycle. With load=1, din=5, en=1: q=5 and no step is taken.
- Hold (en=0 for 5 cycles at q=6): q stays 6, j_dbg=k_dbg=0, tc=0, and wrap=0.
- Reset mid-operation (rst=1 on the cycle q=9 with en=1, up=1): q=0 and wrap=0 on the next cycle. The following en edge gives q=1.
- Full-range parameter (WIDTH=3, MOD=8, up, en for 9 cycles): q goes 0..7,0. wrap pulses once, and no cell ever receives J=K=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared JK storage-cell command encoding and per-bit excitation helper.
// Used by the JK cell and by the modulo counter that drives it.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_cmd_t;

  // Minimal command that moves one bit from cur to nxt; toggle is never chosen.
  function automatic jk_cmd_t jk_excite(input logic cur, input logic nxt);
    jk_cmd_t cmd;
    cmd = HOLD;
    if (cur != nxt) cmd = nxt ? SET : RST;
    return cmd;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One edge-triggered JK storage bit; 1-cycle update, no backpressure.
// Has no reset of its own: the owner clears it by driving J=0, K=1.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    case (jk_cmd_t'({j, k}))
      HOLD:    q <= q;
      RST:     q <= 1'b0;
      SET:     q <= 1'b1;
      default: q <= ~q;
    endcase
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter stored in JK cells; 1-cycle count/load latency, no backpressure.
// Priority per edge: rst > load > en > hold; tc is combinational, wrap/load_err are registered pulses.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err,
  output logic [WIDTH-1:0] j_dbg,
  output logic [WIDTH-1:0] k_dbg
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   din_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_top;
  logic             at_zero;
  logic             din_bad;

  assign q_ext   = {1'b0, q};
  assign din_ext = {1'b0, din};
  // Extra bit keeps q+1 from overflowing before the modulus compare.
  assign inc_ext = q_ext + (WIDTH+1)'(1);
  assign at_top  = (q == TOP);
  assign at_zero = (q == '0);
  assign din_bad = (din_ext >= MOD_EXT);

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = din_bad ? TOP : din;
    end else if (en && up) begin
      // An out-of-range q also lands here and restarts at 0 without a wrap.
      nxt = (inc_ext >= MOD_EXT) ? '0 : inc_ext[WIDTH-1:0];
    end else if (en) begin
      nxt = at_zero ? TOP : q - WIDTH'(1);
    end
  end

  always_comb begin
    jk_cmd_t cmd;
    cmd = HOLD;
    j   = '0;
    k   = '0;
    if (rst) begin
      k = '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd  = jk_excite(q[i], nxt[i]);
        j[i] = cmd[1];
        k[i] = cmd[0];
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .j   (j[gi]),
      .k   (k[gi]),
      .q   (q[gi])
    );
  end

  assign j_dbg = j;
  assign k_dbg = k;
  assign tc    = en & ~load & (up ? at_top : at_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc;
      load_err <= load & din_bad;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (MOD=10 and full-range MOD=8 instances) with a result scoreboard.
module tb_jk_mod_counter;

  logic       clk;
  logic       rst, en, up, load;
  logic [3:0] din, q, j_dbg, k_dbg;
  logic       tc, wrap, load_err;

  logic       rst8, en8, up8, load8;
  logic [2:0] din8, q8, j8, k8;
  logic       tc8, wrap8, lerr8;

  typedef struct {
    logic [3:0] q;
    logic       wrap;
    logic       lerr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err),
    .j_dbg(j_dbg), .k_dbg(k_dbg)
  );

  jk_mod_counter #(.WIDTH(3), .MOD(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .din(din8),
    .q(q8), .tc(tc8), .wrap(wrap8), .load_err(lerr8),
    .j_dbg(j8), .k_dbg(k8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setin(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] d);
    rst = r; en = e; up = u; load = l; din = d;
    #1;
  endtask

  // Push the expected post-edge state, take the edge, then pop and compare.
  task automatic tick(input bit sel, input logic [3:0] eq, input logic ew, input logic el,
                      input string tag);
    exp_t e;
    sb.push_back('{eq, ew, el});
    @(posedge clk);
    #2;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      if (sel) begin
        chk({tag, ".q"},    32'(q8),    32'(e.q));
        chk({tag, ".wrap"}, 32'(wrap8), 32'(e.wrap));
        chk({tag, ".lerr"}, 32'(lerr8), 32'(e.lerr));
      end else begin
        chk({tag, ".q"},    32'(q),        32'(e.q));
        chk({tag, ".wrap"}, 32'(wrap),     32'(e.wrap));
        chk({tag, ".lerr"}, 32'(load_err), 32'(e.lerr));
      end
    end
  endtask

  initial begin
    int cur, nxt;
    rst8 = 1'b1; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; din8 = 3'd0;
    setin(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, "reset");

    // Count up through the terminal value and wrap.
    setin(0, 1, 1, 0, 0);
    cur = 0;
    for (int i = 0; i < 11; i++) begin
      chk("tc_up", 32'(tc), 32'(cur == 9));
      nxt = (cur == 9) ? 0 : cur + 1;
      tick(0, 4'(nxt), cur == 9, 0, "count_up");
      cur = nxt;
    end

    // Down wrap from 0 to 9.
    setin(0, 0, 1, 1, 0);
    tick(0, 0, 0, 0, "load0");
    setin(0, 1, 0, 0, 0);
    chk("tc_down0", 32'(tc), 32'(1));
    chk("j_0to9", 32'(j_dbg), 32'(4'b1001));
    chk("k_0to9", 32'(k_dbg), 32'(4'b0000));
    tick(0, 9, 1, 0, "down_wrap");
    chk("tc_down9", 32'(tc), 32'(0));
    chk("j_9to8", 32'(j_dbg), 32'(4'b0000));
    chk("k_9to8", 32'(k_dbg), 32'(4'b0001));
    tick(0, 8, 0, 0, "down");

    // Out-of-range load clamps; load beats en.
    setin(0, 0, 1, 1, 12);
    tick(0, 9, 0, 1, "clamp");
    setin(0, 1, 1, 1, 5);
    chk("tc_load", 32'(tc), 32'(0));
    tick(0, 5, 0, 0, "load_en");
    setin(0, 1, 1, 0, 0);
    tick(0, 6, 0, 0, "step_to6");

    // Hold at 6.
    setin(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_j", 32'(j_dbg), 32'(0));
      chk("hold_k", 32'(k_dbg), 32'(0));
      chk("hold_tc", 32'(tc), 32'(0));
      tick(0, 6, 0, 0, "hold");
    end

    // Reset coinciding with a terminal step and with a bad load.
    setin(0, 0, 1, 1, 9);
    tick(0, 9, 0, 0, "load9");
    setin(1, 1, 1, 0, 0);
    chk("tc_rst", 32'(tc), 32'(1));
    chk("j_rst", 32'(j_dbg), 32'(4'b0000));
    chk("k_rst", 32'(k_dbg), 32'(4'b1111));
    tick(0, 0, 0, 0, "rst_mid");
    setin(1, 0, 1, 1, 15);
    tick(0, 0, 0, 0, "rst_load");
    setin(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, "post_rst_idle");
    setin(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, "first_step");
    setin(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, "dir_down");
    setin(0, 1, 1, 0, 0);
    tick(0, 1, 0, 0, "dir_up");

    // Full-range instance: natural binary wrap, never a toggle command.
    tick(1, 0, 0, 0, "b_reset");
    rst8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
    #1;
    cur = 0;
    for (int i = 0; i < 9; i++) begin
      chk("b_tc", 32'(tc8), 32'(cur == 7));
      chk("b_no_toggle", 32'(j8 & k8), 32'(0));
      nxt = (cur + 1) % 8;
      tick(1, 4'(nxt), cur == 7, 0, "b_count");
      cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
